// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encodings and
// the helper used to size its internal counters.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILISE = 3'd2,
    READY     = 3'd3,
    FAILED    = 3'd4
  } pll_state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  // Capture the asynchronous input, then re-time it once more to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a debounced lock
// within a timeout window, retries a bounded number of times, and reports
// readiness, sticky failure and a saturating lock-loss count.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  clear_counts,
  output logic                  pll_rst,
  output logic                  sys_ready,
  output logic                  lock_fail,
  output logic [2:0]            retry_count,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            state_dbg
);

  localparam int RST_W  = clog2_min1(RST_PULSE_CYCLES);
  localparam int TO_W   = clog2_min1(LOCK_TIMEOUT_CYCLES);
  localparam int STAB_W = clog2_min1(LOCK_STABLE_CYCLES);

  localparam logic [RST_W-1:0]  RST_LAST   = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]        RETRY_LAST = 3'(MAX_RETRIES - 1);

  pll_state_e        state, state_nxt;
  logic [RST_W-1:0]  rst_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic              locked_s;
  logic              rst_done, timeout, stab_done, acquiring, lost_ready;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  assign rst_done   = (rst_cnt == RST_LAST);
  assign timeout    = (to_cnt == TO_LAST);
  assign stab_done  = (stab_cnt == STAB_LAST);
  assign acquiring  = (state == WAIT_LOCK) || (state == STABILISE);
  assign lost_ready = (state == READY) && !locked_s;
  assign state_dbg  = state;

  // Next-state decision; the timeout outranks any lock observation in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RESET_PLL: if (rst_done) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        if (timeout)       state_nxt = (retry_count == RETRY_LAST) ? FAILED : RESET_PLL;
        else if (locked_s) state_nxt = STABILISE;
      end
      STABILISE: begin
        if (timeout)        state_nxt = (retry_count == RETRY_LAST) ? FAILED : RESET_PLL;
        else if (!locked_s) state_nxt = WAIT_LOCK;
        else if (stab_done) state_nxt = READY;
      end
      READY:     if (!locked_s) state_nxt = RESET_PLL;
      FAILED:    state_nxt = FAILED;
      default:   state_nxt = RESET_PLL;
    endcase
  end

  // State, phase counters, status counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= RESET_PLL;
      rst_cnt     <= '0;
      to_cnt      <= '0;
      stab_cnt    <= '0;
      retry_count <= 3'd0;
      loss_count  <= '0;
      pll_rst     <= 1'b1;
      sys_ready   <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Pulse-width counter only runs while the PLL is held in reset.
      if ((state == RESET_PLL) && !rst_done) rst_cnt <= rst_cnt + 1'b1;
      else                                   rst_cnt <= '0;

      // Timeout window spans WAIT_LOCK and STABILISE together, so lock chatter does not restart it.
      if (acquiring && !timeout) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;

      // Consecutive-lock counter; any low sample restarts qualification.
      if ((state == STABILISE) && locked_s && !stab_done) stab_cnt <= stab_cnt + 1'b1;
      else                                                stab_cnt <= '0;

      if (acquiring && timeout) retry_count <= retry_count + 3'd1;
      else if (lost_ready)      retry_count <= 3'd0;

      // Clear takes priority over a simultaneous loss.
      if (clear_counts)                        loss_count <= '0;
      else if (lost_ready && loss_count != '1) loss_count <= loss_count + 1'b1;

      pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAILED);
      sys_ready <= (state_nxt == READY);
      lock_fail <= (state_nxt == FAILED);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with a phase/streak reference model.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE   = 4;
  localparam int TIMEOUT     = 100;
  localparam int STABLE      = 16;
  localparam int MAX_RETRIES = 3;
  localparam int LOSS_W      = 2;
  localparam int LOSS_MAX    = (1 << LOSS_W) - 1;

  // Reference model phases: PLL held in reset, acquiring lock, ready, failed.
  localparam int P_PULSE  = 0;
  localparam int P_ACQ    = 1;
  localparam int P_READY  = 2;
  localparam int P_FAILED = 3;

  localparam logic [10:0] RST_VEC = 11'b100_0000_0000;

  typedef struct packed {
    int phase;
    int elapsed;
    int streak;
    int retries;
    int losses;
  } model_t;

  logic refclk = 1'b0;
  logic rst, pll_locked, clear_counts;
  logic pll_rst, sys_ready, lock_fail;
  logic [2:0] retry_count, state_dbg;
  logic [LOSS_W-1:0] loss_count;

  int checks = 0;
  int errors = 0;

  model_t m_cur;
  logic   m_h1, m_h2;
  logic [10:0] dut_vec, exp_vec;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (MAX_RETRIES),
    .LOSS_CNT_W          (LOSS_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .clear_counts (clear_counts),
    .pll_rst      (pll_rst),
    .sys_ready    (sys_ready),
    .lock_fail    (lock_fail),
    .retry_count  (retry_count),
    .loss_count   (loss_count),
    .state_dbg    (state_dbg)
  );

  // One clock of the supervisor's rules, expressed as time-in-phase and lock streak.
  function automatic model_t model_step(model_t m, logic ls, logic clr);
    model_t n = m;
    case (m.phase)
      P_PULSE: begin
        n.elapsed = m.elapsed + 1;
        if (n.elapsed == RST_PULSE) begin
          n.phase = P_ACQ; n.elapsed = 0; n.streak = 0;
        end
      end
      P_ACQ: begin
        n.elapsed = m.elapsed + 1;
        if (n.elapsed == TIMEOUT) begin
          n.retries = m.retries + 1;
          n.phase   = (n.retries == MAX_RETRIES) ? P_FAILED : P_PULSE;
          n.elapsed = 0; n.streak = 0;
        end else begin
          n.streak = ls ? m.streak + 1 : 0;
          if (n.streak == STABLE + 1) n.phase = P_READY;
        end
      end
      P_READY: begin
        if (!ls) begin
          n.losses  = (m.losses == LOSS_MAX) ? LOSS_MAX : m.losses + 1;
          n.retries = 0; n.phase = P_PULSE; n.elapsed = 0;
        end
      end
      default: ;
    endcase
    if (clr) n.losses = 0;
    return n;
  endfunction

  function automatic logic [10:0] model_outs(model_t m);
    logic [2:0] st;
    case (m.phase)
      P_PULSE: st = 3'd0;
      P_ACQ:   st = (m.streak == 0) ? 3'd1 : 3'd2;
      P_READY: st = 3'd3;
      default: st = 3'd4;
    endcase
    return {(m.phase == P_PULSE) || (m.phase == P_FAILED), m.phase == P_READY,
            m.phase == P_FAILED, 3'(m.retries), LOSS_W'(m.losses), st};
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_h1  <= 1'b0;
      m_h2  <= 1'b0;
      m_cur <= '0;
    end else begin
      m_h1  <= pll_locked;
      m_h2  <= m_h1;
      m_cur <= model_step(m_cur, m_h2, clear_counts);
    end
  end

  assign dut_vec = {pll_rst, sys_ready, lock_fail, retry_count, loss_count, state_dbg};
  assign exp_vec = model_outs(m_cur);

  // Stimulus only: reset, then release on a falling edge.
  task automatic start_run(input logic lk);
    @(negedge refclk);
    rst = 1'b1; pll_locked = lk; clear_counts = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; clear_counts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++; $display("FAIL reset_values i=%0d actual=%b required=%b", i, dut_vec, RST_VEC);
      end
      pll_locked = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_nominal();
    int hi = 0;
    start_run(1'b0);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL nominal_model c=%0d actual=%b required=%b", c, dut_vec, exp_vec);
      end
      if (pll_rst) hi++;
      if (c == 28) begin
        checks++;
        if (sys_ready !== 1'b0) begin errors++; $display("FAIL nominal_ready_early c=%0d actual=%b required=0", c, sys_ready); end
      end
      if (c == 29) begin
        checks++;
        if (sys_ready !== 1'b1) begin errors++; $display("FAIL nominal_ready_at_29 actual=%b required=1", sys_ready); end
      end
      if (c == 10) pll_locked = 1'b1;
      @(negedge refclk);
    end
    checks++;
    if (hi != RST_PULSE) begin errors++; $display("FAIL nominal_pll_rst_width actual=%0d required=%0d", hi, RST_PULSE); end
    checks++;
    if (retry_count !== 3'd0) begin errors++; $display("FAIL nominal_retry actual=%0d required=0", retry_count); end
  endtask

  task automatic test_loss();
    int waited, hold, low_len;
    logic [LOSS_W-1:0] want;
    start_run(1'b1);
    for (int k = 1; k <= 5; k++) begin
      waited = 0;
      while (sys_ready !== 1'b1 && waited < 200) begin
        checks++;
        if (dut_vec !== exp_vec) begin errors++; $display("FAIL loss_model_wait k=%0d actual=%b required=%b", k, dut_vec, exp_vec); end
        @(negedge refclk);
        waited++;
      end
      checks++;
      if (sys_ready !== 1'b1) begin errors++; $display("FAIL loss_ready_timeout k=%0d actual=%b required=1", k, sys_ready); end
      hold = $urandom_range(0, 5);
      for (int h = 0; h < hold; h++) begin
        @(negedge refclk);
        checks++;
        if (dut_vec !== exp_vec) begin errors++; $display("FAIL loss_model_hold k=%0d actual=%b required=%b", k, dut_vec, exp_vec); end
      end
      low_len = $urandom_range(1, 3);
      pll_locked = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        @(negedge refclk);
        checks++;
        if (dut_vec !== exp_vec) begin errors++; $display("FAIL loss_model_drop k=%0d j=%0d actual=%b required=%b", k, j, dut_vec, exp_vec); end
        if (j == 2) begin
          checks++;
          if (sys_ready !== 1'b1) begin errors++; $display("FAIL loss_ready_edge2 k=%0d actual=%b required=1", k, sys_ready); end
        end
        if (j == 3) begin
          want = (k > LOSS_MAX) ? LOSS_W'(LOSS_MAX) : LOSS_W'(k);
          checks++;
          if (sys_ready !== 1'b0) begin errors++; $display("FAIL loss_ready_edge3 k=%0d actual=%b required=0", k, sys_ready); end
          checks++;
          if (loss_count !== want) begin errors++; $display("FAIL loss_count k=%0d actual=%0d required=%0d", k, loss_count, want); end
          checks++;
          if (retry_count !== 3'd0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL loss_retry_state k=%0d actual=%0d/%0d required=0/0", k, retry_count, state_dbg);
          end
        end
        if (j == low_len) pll_locked = 1'b1;
      end
    end
  endtask

  task automatic test_rst_stab();
    int waited = 0;
    while (state_dbg !== 3'd2 && waited < 200) begin @(negedge refclk); waited++; end
    checks++;
    if (state_dbg !== 3'd2) begin errors++; $display("FAIL rst_stab_reach actual=%0d required=2", state_dbg); end
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin errors++; $display("FAIL rst_stab_values actual=%b required=%b", dut_vec, RST_VEC); end
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int waited;
    logic [LOSS_W-1:0] want;
    start_run(1'b1);
    for (int k = 1; k <= 2; k++) begin
      waited = 0;
      while (sys_ready !== 1'b1 && waited < 200) begin @(negedge refclk); waited++; end
      checks++;
      if (sys_ready !== 1'b1) begin errors++; $display("FAIL clear_ready_timeout k=%0d actual=%b required=1", k, sys_ready); end
      pll_locked = 1'b0;
      for (int j = 1; j <= 3; j++) begin
        @(negedge refclk);
        checks++;
        if (dut_vec !== exp_vec) begin errors++; $display("FAIL clear_model k=%0d j=%0d actual=%b required=%b", k, j, dut_vec, exp_vec); end
        if (j == 2 && k == 2) clear_counts = 1'b1;
        if (j == 3) begin
          clear_counts = 1'b0;
          pll_locked   = 1'b1;
          want = (k == 1) ? LOSS_W'(1) : LOSS_W'(0);
          checks++;
          if (loss_count !== want) begin errors++; $display("FAIL clear_loss_count k=%0d actual=%0d required=%0d", k, loss_count, want); end
          checks++;
          if (state_dbg !== 3'd0 || sys_ready !== 1'b0) begin
            errors++; $display("FAIL clear_state k=%0d actual=%0d/%b required=0/0", k, state_dbg, sys_ready);
          end
        end
      end
    end
  endtask

  task automatic test_chatter();
    int hi_left, lo_left, rise_c;
    logic saw_ready, saw_stab, prev_rst;
    start_run(1'b1);
    hi_left = $urandom_range(3, 14); lo_left = 0; rise_c = -1;
    saw_ready = 1'b0; saw_stab = 1'b0; prev_rst = 1'b1;
    for (int c = 0; c < 120; c++) begin
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL chatter_model c=%0d actual=%b required=%b", c, dut_vec, exp_vec); end
      if (sys_ready) saw_ready = 1'b1;
      if (state_dbg == 3'd2) saw_stab = 1'b1;
      if (pll_rst && !prev_rst && rise_c < 0) rise_c = c;
      prev_rst = pll_rst;
      if (c == 110) begin
        checks++;
        if (retry_count !== 3'd1) begin errors++; $display("FAIL chatter_retry actual=%0d required=1", retry_count); end
      end
      if (pll_locked) begin
        hi_left--;
        if (hi_left == 0) begin pll_locked = 1'b0; lo_left = $urandom_range(1, 3); end
      end else begin
        lo_left--;
        if (lo_left == 0) begin pll_locked = 1'b1; hi_left = $urandom_range(3, 14); end
      end
      @(negedge refclk);
    end
    checks++;
    if (saw_ready) begin errors++; $display("FAIL chatter_never_ready actual=1 required=0"); end
    checks++;
    if (!saw_stab) begin errors++; $display("FAIL chatter_stabilise_seen actual=0 required=1"); end
    checks++;
    if (rise_c != RST_PULSE + TIMEOUT) begin
      errors++; $display("FAIL chatter_timeout_cycle actual=%0d required=%0d", rise_c, RST_PULSE + TIMEOUT);
    end
  endtask

  task automatic test_never_lock();
    int runs[$];
    int run = 0;
    int first_fail = -1;
    logic held = 1'b1;
    start_run(1'b0);
    for (int c = 0; c < 1312; c++) begin
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL never_model c=%0d actual=%b required=%b", c, dut_vec, exp_vec); end
      if (!pll_rst) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
      if (lock_fail && first_fail < 0) first_fail = c;
      if (first_fail >= 0 && !lock_fail) held = 1'b0;
      @(negedge refclk);
    end
    checks++;
    if (runs.size() != MAX_RETRIES) begin errors++; $display("FAIL never_pulse_count actual=%0d required=%0d", runs.size(), MAX_RETRIES); end
    foreach (runs[i]) begin
      checks++;
      if (runs[i] != TIMEOUT) begin errors++; $display("FAIL never_low_len i=%0d actual=%0d required=%0d", i, runs[i], TIMEOUT); end
    end
    checks++;
    if (first_fail != MAX_RETRIES * (RST_PULSE + TIMEOUT)) begin
      errors++; $display("FAIL never_fail_cycle actual=%0d required=%0d", first_fail, MAX_RETRIES * (RST_PULSE + TIMEOUT));
    end
    checks++;
    if (!held) begin errors++; $display("FAIL never_fail_held actual=0 required=1"); end
    checks++;
    if ({pll_rst, lock_fail, retry_count, state_dbg} !== {1'b1, 1'b1, 3'd3, 3'd4}) begin
      errors++; $display("FAIL never_final actual=%b%b/%0d/%0d required=11/3/4", pll_rst, lock_fail, retry_count, state_dbg);
    end
  endtask

  task automatic test_rst_failed();
    @(negedge refclk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin errors++; $display("FAIL rst_failed_values actual=%b required=%b", dut_vec, RST_VEC); end
    for (int i = 0; i < 2; i++) begin
      pll_locked = ~pll_locked;
      @(negedge refclk);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL rst_failed_hold i=%0d actual=%b required=%b", i, dut_vec, exp_vec); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_loss();
    test_rst_stab();
    test_clear();
    test_chatter();
    test_never_lock();
    test_rst_failed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
